// File: rtl/std_types.sv
// Shared scalar and word types used across the mixed-signal control codebase.
package std_types;

    typedef logic        bool;
    typedef logic [7:0]  u8;
    typedef logic [15:0] u16;

endpackage

// File: rtl/umul_pkg.sv
// Shared state and mode encodings for the sequential unsigned multiplier.
package umul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } umul_state_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } umul_mode_t;

endpackage

// File: rtl/umul_step.sv
// One multiply step: adds the partial products of BITS_PER_CYCLE multiplier bits
// to the running accumulator. The multiplicand arrives already shifted to position.
module umul_step #(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    input  logic [2*DATA_WIDTH-1:0]   mcand,
    input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
    output logic [2*DATA_WIDTH-1:0]   acc_out
);

    always_comb begin
        acc_out = acc_in;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_bits[j]) begin
                acc_out = acc_out + (mcand << j);
            end
        end
    end

endmodule

// File: rtl/umul_seq.sv
// Sequential unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per cycle,
// with wrap or saturate result formatting and a valid/ready handshake on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   BUSY  | accumulating partial products, counter counts down to 0
//   DONE  | result held on out/ov/sig_ov until out_ready
module umul_seq
    import umul_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  sat_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] ov,
    output logic                  sig_ov
);

    localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = 2 * DATA_WIDTH;

    if (DATA_WIDTH < 2 || (DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("umul_seq: BITS_PER_CYCLE must divide DATA_WIDTH and DATA_WIDTH must be >= 2");
    end

    umul_state_t             state, state_d;
    umul_mode_t              mode_q;
    logic [AW-1:0]           acc_q;
    logic [AW-1:0]           acc_next;
    logic [AW-1:0]           mcand_q;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    accept;

    assign accept = in_valid && (state == IDLE);

    umul_step #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_in      (acc_q),
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_out     (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)     state_d = BUSY;
            BUSY:    if (cnt_q == '0)  state_d = DONE;
            DONE:    if (out_ready)    state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Multiplier shifts right and multiplicand left so each step sees the next bit group at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_WRAP;
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_WIDTH{1'b0}}, in0};
            mplier_q <= in1;
            cnt_q    <= CNT_W'(N - 1);
            mode_q   <= umul_mode_t'(sat_mode);
        end else if (state == BUSY) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    logic [DATA_WIDTH-1:0] prod_hi, prod_lo;
    logic                  prod_big;

    assign prod_hi  = acc_q[AW-1:DATA_WIDTH];
    assign prod_lo  = acc_q[DATA_WIDTH-1:0];
    assign prod_big = |prod_hi;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Excess over all-ones, modulo 2^DATA_WIDTH, only depends on the low half.
    always_comb begin
        out    = '0;
        ov     = '0;
        sig_ov = 1'b0;
        if (out_valid) begin
            sig_ov = prod_big;
            if (mode_q == MODE_SAT) begin
                out = prod_big ? {DATA_WIDTH{1'b1}} : prod_lo;
                ov  = prod_big ? (prod_lo - {DATA_WIDTH{1'b1}}) : '0;
            end else begin
                out = prod_lo;
                ov  = prod_hi;
            end
        end
    end

endmodule
